// File: rtl/transpose_buffer_controller_if.sv
// ============================================================================
// Module  : transpose_buffer_controller_if
// Purpose : Row-in / column-out handshake and cell-control bundle for the
//           transpose buffer controller.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface transpose_buffer_controller_if #(
  parameter int CNT_WIDTH = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_first;
  logic                 out_last;
  logic [CNT_WIDTH-1:0] out_index;
  logic                 cell_enable;
  logic                 cell_direction;
  logic                 busy;

  // Controller side
  modport slave (
    input  in_valid,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_first,
    output out_last,
    output out_index,
    output cell_enable,
    output cell_direction,
    output busy
  );

  // Environment side: upstream producer, downstream consumer, cell array
  modport master (
    output in_valid,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_first,
    input  out_last,
    input  out_index,
    input  cell_enable,
    input  cell_direction,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/transpose_buffer_controller.sv
// ============================================================================
// Module  : transpose_buffer_controller
// Purpose : Alternating-direction control for an N x N transpose cell array;
//           rows stream in while the previous block's columns stream out.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module transpose_buffer_controller #(
  parameter int BLOCK_SIZE = 4,
  parameter int CNT_WIDTH  = 5
) (
  input  wire                           clock,
  input  wire                           reset,
  transpose_buffer_controller_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(BLOCK_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 dir_q, dir_d;

  logic                 in_ready_w;
  logic                 out_valid_w;
  logic                 beat_w;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      count_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dir_d       = dir_q;
    in_ready_w  = 1'b0;
    out_valid_w = 1'b0;
    beat_w      = 1'b0;

    if (!reset) begin
      case (state_q)
        EMPTY: begin
          in_ready_w = 1'b1;
          beat_w     = bus.in_valid;
        end
        STREAM: begin
          out_valid_w = bus.in_valid;
          in_ready_w  = bus.out_ready;
          beat_w      = bus.in_valid && bus.out_ready;
          // Drain only at a block boundary and only when no new row competes
          if ((count_q == '0) && bus.flush && !bus.in_valid) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          out_valid_w = 1'b1;
          beat_w      = bus.out_ready;
        end
        default: begin
          state_d = EMPTY;
          count_d = '0;
        end
      endcase

      if (beat_w) begin
        if (count_q == C_LAST) begin
          count_d = '0;
          dir_d   = ~dir_q;
          case (state_q)
            EMPTY:   state_d = STREAM;
            DRAIN:   state_d = EMPTY;
            default: state_d = STREAM;
          endcase
        end else begin
          count_d = count_q + C_ONE;
        end
      end
    end
  end

  assign bus.in_ready       = in_ready_w;
  assign bus.out_valid      = out_valid_w;
  assign bus.cell_enable    = beat_w;
  assign bus.cell_direction = dir_q;
  assign bus.out_index      = out_valid_w ? count_q : '0;
  assign bus.out_first      = out_valid_w && (count_q == '0);
  assign bus.out_last       = out_valid_w && (count_q == C_LAST);
  assign bus.busy           = (state_q != EMPTY) || (count_q != '0);

endmodule

`default_nettype wire
